// File: rtl/ffra_arbiter.sv
// rtl/ffra_arbiter.sv - round-robin issue arbiter sharing one fixed-latency multiply-add pipeline
// Credit-based issue plus a latency-matched tag pipe so results land in a response FIFO without loss.
module ffra_arbiter #(
  parameter int BITS  = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*BITS-1:0]        req_a,
  input  logic [NREQ*BITS-1:0]        req_b,
  input  logic [NREQ*2*BITS-1:0]      req_ci,
  output logic [BITS-1:0]             mac_a,
  output logic [BITS-1:0]             mac_b,
  output logic [2*BITS-1:0]           mac_ci,
  input  logic [2*BITS-1:0]           mac_o,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [2*BITS-1:0]           rsp_data,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic                        busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = 2*BITS + IDW;

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic [IDW-1:0]      r_ptr;
  logic [LAT-1:0]      r_tag_v;
  logic [IDW-1:0]      r_tag_id [LAT];
  logic [AW:0]         r_inflight;
  logic [AW:0]         r_count;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [DW-1:0]       r_mem [DEPTH];

  logic [AW+1:0]       w_credit_sum;
  logic                w_can_issue;
  logic                w_grant_any;
  logic [IDW-1:0]      w_grant_id;
  logic [IDW-1:0]      w_idx;
  logic                w_push;
  logic                w_pop;
  logic [DW-1:0]       w_head;

  // Reset asserts immediately but releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // A pop only frees a credit once the count register has actually dropped.
  assign w_credit_sum = (AW+2)'(r_inflight) + (AW+2)'(r_count);
  assign w_can_issue  = w_credit_sum < (AW+2)'(DEPTH);

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (w_rst_n && w_can_issue && !w_grant_any && req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  assign req_ready = w_grant_any ? (NREQ'(1) << w_grant_id) : '0;
  assign mac_a     = w_grant_any ? req_a[w_grant_id*BITS +: BITS] : '0;
  assign mac_b     = w_grant_any ? req_b[w_grant_id*BITS +: BITS] : '0;
  assign mac_ci    = w_grant_any ? req_ci[w_grant_id*2*BITS +: 2*BITS] : '0;

  assign w_push = r_tag_v[LAT-1];
  assign w_pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ptr      <= '0;
      r_tag_v    <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      if (w_grant_any)
        r_ptr <= (w_grant_id == IDW'(NREQ-1)) ? '0 : w_grant_id + IDW'(1);
      r_tag_v     <= {r_tag_v[LAT-2:0], w_grant_any};
      r_tag_id[0] <= w_grant_id;
      for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
      case ({w_grant_any, w_push})
        2'b10:   r_inflight <= r_inflight + (AW+1)'(1);
        2'b01:   r_inflight <= r_inflight - (AW+1)'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  // Payload storage needs no reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {mac_o, r_tag_id[LAT-1]};
  end

  assign w_head    = r_mem[r_rptr];
  assign rsp_valid = (r_count != '0);
  assign rsp_data  = rsp_valid ? w_head[DW-1:IDW] : '0;
  assign rsp_id    = rsp_valid ? w_head[IDW-1:0] : '0;
  assign busy      = (r_inflight != '0) | rsp_valid;

  a_no_overflow: assert property (@(posedge clk) disable iff (!w_rst_n)
    !(w_push && (r_count == (AW+1)'(DEPTH))));

endmodule

// File: tb/tb_ffra_arbiter.sv
// tb/tb_ffra_arbiter.sv - directed scoreboard bench for ffra_arbiter with a modelled 4-stage MAC
module tb_ffra_arbiter;

  localparam int BITS  = 32;
  localparam int NREQ  = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*BITS-1:0]   req_a;
  logic [NREQ*BITS-1:0]   req_b;
  logic [NREQ*2*BITS-1:0] req_ci;
  logic [BITS-1:0]        mac_a;
  logic [BITS-1:0]        mac_b;
  logic [2*BITS-1:0]      mac_ci;
  logic [2*BITS-1:0]      mac_o;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2*BITS-1:0]      rsp_data;
  logic [1:0]             rsp_id;
  logic                   busy;

  logic [63:0] r_p0, r_p1, r_p2, r_p3;
  logic [65:0] sb [$];
  logic [65:0] mon_e;
  int          n_checks;
  int          n_errors;

  logic [31:0] rr_a   [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
  logic [31:0] rr_b   [4] = '{32'd3, 32'd5, 32'd7, 32'd9};
  logic [63:0] rr_ci  [4] = '{64'd1, 64'd2, 64'd3, 64'd4};
  logic [63:0] rr_exp [4] = '{64'd7, 64'd22, 64'd45, 64'd76};

  ffra_arbiter #(.BITS(BITS), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .mac_a(mac_a), .mac_b(mac_b), .mac_ci(mac_ci), .mac_o(mac_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_p0 <= 64'(mac_a) * 64'(mac_b) + mac_ci;
    r_p1 <= r_p0;
    r_p2 <= r_p1;
    r_p3 <= r_p2;
  end
  assign mac_o = r_p3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected actual id=%0d data=0x%0h required=no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", rsp_data, mon_e[63:0]);
        check("rsp_id", 64'(rsp_id), 64'(mon_e[65:64]));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b, input logic [63:0] ci);
    req_a[id*BITS +: BITS]     = a;
    req_b[id*BITS +: BITS]     = b;
    req_ci[id*2*BITS +: 2*BITS] = ci;
  endtask

  task automatic load_rr();
    for (int i = 0; i < NREQ; i++) set_ops(i, rr_a[i], rr_b[i], rr_ci[i]);
  endtask

  task automatic check_reset();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_mac_a",     64'(mac_a), 64'd0);
    check("rst_mac_b",     64'(mac_b), 64'd0);
    check("rst_mac_ci",    mac_ci, 64'd0);
    check("rst_rsp_data",  rsp_data, 64'd0);
    check("rst_rsp_id",    64'(rsp_id), 64'd0);
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    req_valid = 4'hF;
    sample();
    check_reset();
    next_cycle();
    rst_n = 1'b1;
    req_valid = 4'h0;
    repeat (3) next_cycle();
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while ((sb.size() != 0 || busy) && cnt < 60) begin
      next_cycle();
      sample();
      cnt++;
    end
    check(name, 64'(sb.size() == 0 && !busy), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=no finish required=finish");
    $fatal(1);
  end

  initial begin
    int first;
    logic [3:0] exp_rdy;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ci    = '0;
    load_rr();
    repeat (2) @(posedge clk);
    do_reset();

    // single op from requester 2
    rsp_ready = 1'b1;
    next_cycle();
    set_ops(2, 32'd3, 32'd5, 64'd7);
    req_valid = 4'b0100;
    sample();
    check("single_ready", 64'(req_ready), 64'h4);
    check("single_mac_a", 64'(mac_a), 64'd3);
    check("single_mac_b", 64'(mac_b), 64'd5);
    check("single_mac_ci", mac_ci, 64'd7);
    sb.push_back({2'd2, 64'd22});
    first = -1;
    for (int c = 1; c <= LAT + 3; c++) begin
      next_cycle();
      req_valid = 4'h0;
      sample();
      if (c == 1) check("single_busy", 64'(busy), 64'd1);
      if (first < 0 && rsp_valid) first = c;
    end
    check("single_latency", 64'(first >= LAT && first <= LAT + 1), 64'd1);
    drain("single_drain");

    // round-robin with all four requesting
    do_reset();
    load_rr();
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req_valid = 4'hF;
      sample();
      check("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
      sb.push_back({2'(k % 4), rr_exp[k % 4]});
    end
    next_cycle();
    req_valid = 4'h0;
    drain("rr_drain");

    // backpressure: fill all credits, then release
    rsp_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      next_cycle();
      req_valid = 4'hF;
      rsp_ready = (k >= 14);
      sample();
      if (k < 8)       exp_rdy = 4'(1 << (k % 4));
      else if (k < 15) exp_rdy = 4'h0;
      else             exp_rdy = 4'(1 << ((k - 15) % 4));
      check("bp_grant", 64'(req_ready), 64'(exp_rdy));
      if (k < 8)       sb.push_back({2'(k % 4), rr_exp[k % 4]});
      else if (k >= 15) sb.push_back({2'((k - 15) % 4), rr_exp[(k - 15) % 4]});
    end
    next_cycle();
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    drain("bp_drain");

    // width extremes on requester 1
    next_cycle();
    set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    req_valid = 4'b0010;
    sample();
    check("wide_ready", 64'(req_ready), 64'h2);
    sb.push_back({2'd1, 64'hFFFF_FFFE_0000_0000});
    next_cycle();
    req_valid = 4'h0;
    drain("wide_drain");

    // idle: operands present but no valid
    load_rr();
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req_valid = 4'h0;
      sample();
      check("idle_mac_a", 64'(mac_a), 64'd0);
      check("idle_mac_b", 64'(mac_b), 64'd0);
      check("idle_mac_ci", mac_ci, 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
    next_cycle();
    req_valid = 4'hF;
    sample();
    check("idle_ptr_grant", 64'(req_ready), 64'h4);
    sb.push_back({2'd2, rr_exp[2]});
    next_cycle();
    req_valid = 4'h0;
    drain("idle_drain");

    // reset while ops are in flight
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      req_valid = 4'(1 << k);
      sample();
      check("mid_grant", 64'(req_ready), 64'(1 << k));
    end
    next_cycle();
    req_valid = 4'b0100;
    rst_n = 1'b0;
    sample();
    check_reset();
    next_cycle();
    rst_n = 1'b1;
    req_valid = 4'h0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      sample();
      check("mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
